// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_MD_DONE = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic        BUBBLE_CTRL  = 1'b0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic if_flush;
        logic id_flush;
        logic ex_bubble;
        logic md_busy;
    } ctrl_t;

    localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                      if_flush: 1'b0, id_flush: 1'b0, ex_bubble: 1'b0,
                                      md_busy: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
// Latency: count reflects an inc one clock edge later.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Load-use stall, taken-branch flush and mul/div freeze sequencing for the 5-stage pipeline.
// Latency: 0-cycle combinational controls; only FSM state and statistics are registered.
// Backpressure: the front end is held by deasserting PC_Write/IF_ID_Write/ID_EX_Write.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_Rs_addr,
    input  logic [4:0]       IF_ID_Rt_addr,
    input  logic             ID_uses_Rt,
    input  logic [4:0]       ID_EX_Rt_addr,
    input  logic             ID_EX_MemRead,
    input  logic             Branch_taken,
    input  logic             MD_start,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             IF_Flush,
    output logic             ID_Flush,
    output logic             EX_Bubble,
    output logic             MD_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MD_CNT_W = $clog2(MD_LATENCY);

    state_t              state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic                freeze;
    logic                load_use;
    ctrl_t               ctrl;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // md_cnt counts the remaining WAIT cycles; DONE is the mul/div's final EX cycle.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (MD_start) begin
                    md_cnt_d = MD_CNT_W'(MD_LATENCY - 2);
                    state_d  = (MD_LATENCY == 2) ? ST_MD_DONE : ST_MD_WAIT;
                end
            end
            ST_MD_WAIT: begin
                md_cnt_d = md_cnt_q - 1'b1;
                if (md_cnt_q == MD_CNT_W'(1)) begin
                    state_d = ST_MD_DONE;
                end
            end
            ST_MD_DONE: state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    always_comb begin
        freeze = 1'b0;
        case (state_q)
            ST_RUN:     freeze = MD_start;
            ST_MD_WAIT: freeze = 1'b1;
            default:    freeze = 1'b0;
        endcase
    end

    assign load_use = ID_EX_MemRead && (ID_EX_Rt_addr != 5'd0) &&
                      ((ID_EX_Rt_addr == IF_ID_Rs_addr) ||
                       (ID_uses_Rt && (ID_EX_Rt_addr == IF_ID_Rt_addr)));

    always_comb begin
        ctrl = CTRL_NORMAL;
        if (!rst_n) begin
            ctrl = CTRL_NORMAL;
        end else if (freeze) begin
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_write = 1'b0;
            ctrl.id_ex_write = 1'b0;
            ctrl.ex_bubble   = 1'b1;
            ctrl.md_busy     = 1'b1;
        end else if (Branch_taken) begin
            // A load-use stall on the same cycle is moot: its ID instruction is wrong-path.
            ctrl.if_flush = 1'b1;
            ctrl.id_flush = 1'b1;
        end else if (load_use) begin
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_write = 1'b0;
            ctrl.id_flush    = 1'b1;
        end
    end

    assign PC_Write    = ctrl.pc_write;
    assign IF_ID_Write = ctrl.if_id_write;
    assign ID_EX_Write = ctrl.id_ex_write;
    assign IF_Flush    = ctrl.if_flush;
    assign ID_Flush    = ctrl.id_flush;
    assign EX_Bubble   = ctrl.ex_bubble;
    assign MD_busy     = ctrl.md_busy;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc   (~ctrl.pc_write),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc   (Branch_taken && !freeze),
        .count (flush_cnt)
    );

    // The EX mul/div cannot be a taken branch, so both together means upstream decode is broken.
    a_no_branch_in_freeze: assert property (@(posedge clk_i) disable iff (!rst_n)
                                            !(freeze && Branch_taken));

endmodule
